// File: rtl/clk_mux_pkg.sv
// Shared types and constants for the sequenced glitch-free output multiplexer.
package clk_mux_pkg;

  // Default parameter values of the top block.
  localparam int DEF_N_IN       = 12;
  localparam int DEF_DRAIN_CYC  = 2;
  localparam int DEF_SETTLE_CYC = 2;

  // One counter serves both DRAIN and SETTLE, so both lengths must fit in it.
  localparam int CNT_W = 4;

  // Switch sequence: gate off, wait, change select, wait, gate back on.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // Counter load value for a phase of n cycles (the counter runs down to 0).
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/clk_mux_seq_if.sv
// Select request channel: requester drives sel_req/sel_vld, the block reports
// acceptance, the applied index and sequence status.
interface clk_mux_seq_if
  import clk_mux_pkg::*;
#(
  parameter int SEL_W = $clog2(DEF_N_IN)
);
  logic [SEL_W-1:0] sel_req;
  logic             sel_vld;
  logic             sel_rdy;
  logic [SEL_W-1:0] cur_sel;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output sel_req, sel_vld,
    input  sel_rdy, cur_sel, busy, done, err
  );

  modport slave (
    input  sel_req, sel_vld,
    output sel_rdy, cur_sel, busy, done, err
  );
endinterface

// File: rtl/clk_mux_sel.sv
// N_IN:1 single-bit selector; purely combinational AND-OR tree so an index
// beyond N_IN-1 simply yields 0 rather than an undefined bit.
module clk_mux_sel #(
  parameter int N_IN  = 12,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  i_min,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_bit
);
  logic [N_IN-1:0] w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_hit
      assign w_hit[gi] = i_min[gi] & (i_sel == SEL_W'(gi));
    end
  endgenerate

  assign o_bit = |w_hit;
endmodule

// File: rtl/clk_mux_seq.sv
// Sequenced output multiplexer: a select change gates the output off for a
// drain period, swaps the index, then gates off for a settle period before
// the registered output is re-enabled.
module clk_mux_seq
  import clk_mux_pkg::*;
#(
  parameter int N_IN       = DEF_N_IN,
  parameter int SEL_W      = $clog2(N_IN),
  parameter int DRAIN_CYC  = DEF_DRAIN_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog,
  input  logic              cenb,
  input  logic              inv,
  input  logic [N_IN-1:0]   min,
  output logic              mout,
  output logic              moutb,
  clk_mux_seq_if.slave      sel_if
);

  generate
    if (N_IN < 2 || N_IN > 64) begin : g_bad_n_in
      $error("clk_mux_seq: N_IN must be in 2..64");
    end
    if (SEL_W < $clog2(N_IN)) begin : g_bad_sel_w
      $error("clk_mux_seq: SEL_W too narrow for N_IN");
    end
    if (DRAIN_CYC < 1 || DRAIN_CYC > 15) begin : g_bad_drain
      $error("clk_mux_seq: DRAIN_CYC must be in 1..15");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("clk_mux_seq: SETTLE_CYC must be in 1..15");
    end
  endgenerate

  // One extra bit so N_IN itself is representable for the range test.
  localparam logic [SEL_W:0]   LP_N_IN     = (SEL_W + 1)'(N_IN);
  localparam logic [CNT_W-1:0] LP_DRAIN_LD = cnt_load(DRAIN_CYC);
  localparam logic [CNT_W-1:0] LP_SETTLE_LD = cnt_load(SETTLE_CYC);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [SEL_W-1:0] r_cur_sel;
  logic [SEL_W-1:0] w_cur_sel_next;
  logic [SEL_W-1:0] r_pend;
  logic [SEL_W-1:0] w_pend_next;
  logic             r_done;
  logic             w_done_next;
  logic             r_err;
  logic             w_err_next;
  logic             r_mout;
  logic             w_mout_next;

  logic             w_run;
  logic             w_gate;
  logic             w_sel_bit;
  logic             w_out_of_range;

  clk_mux_sel #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_sel (
    .i_min (min),
    .i_sel (r_cur_sel),
    .o_bit (w_sel_bit)
  );

  assign w_run          = (r_state == ST_RUN);
  assign w_gate         = w_run & ~cenb;
  assign w_out_of_range = ({1'b0, sel_if.sel_req} >= LP_N_IN);
  assign w_mout_next    = w_gate & ~prog & (w_sel_bit ^ inv);

  // Next-state and status logic of the switch sequencer.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_cur_sel_next = r_cur_sel;
    w_pend_next    = r_pend;
    w_done_next    = 1'b0;
    w_err_next     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (sel_if.sel_vld) begin
          if (w_out_of_range) begin
            w_err_next = 1'b1;
          end else if (sel_if.sel_req == r_cur_sel) begin
            // Nothing to switch; acknowledge without gating the output.
            w_done_next = 1'b1;
          end else begin
            w_pend_next  = sel_if.sel_req;
            w_cnt_next   = LP_DRAIN_LD;
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (r_cnt == '0) begin
          w_state_next = ST_SWITCH;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_SWITCH: begin
        w_cur_sel_next = r_pend;
        w_cnt_next     = LP_SETTLE_LD;
        w_state_next   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_next = ST_RUN;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State, counter, select and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_cur_sel <= '0;
      r_pend    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_mout    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_cur_sel <= w_cur_sel_next;
      r_pend    <= w_pend_next;
      r_done    <= w_done_next;
      r_err     <= w_err_next;
      r_mout    <= w_mout_next;
    end
  end

  assign mout           = r_mout;
  assign moutb          = ~r_mout;
  assign sel_if.sel_rdy = w_run;
  assign sel_if.busy    = ~w_run;
  assign sel_if.cur_sel = r_cur_sel;
  assign sel_if.done    = r_done;
  assign sel_if.err     = r_err;

endmodule

// File: tb/tb_clk_mux_seq.sv
// Scoreboard bench for clk_mux_seq: a timeline model predicts per-cycle
// outputs and done/err events; a negedge monitor pops and compares.
module tb_clk_mux_seq;
  import clk_mux_pkg::*;

  localparam int N  = 12;
  localparam int SW = $clog2(N);
  localparam int D  = 2;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog;
  logic          cenb;
  logic          inv;
  logic [N-1:0]  min;
  logic          mout;
  logic          moutb;

  clk_mux_seq_if #(.SEL_W(SW)) sif ();

  clk_mux_seq #(
    .N_IN       (N),
    .SEL_W      (SW),
    .DRAIN_CYC  (D),
    .SETTLE_CYC (S)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .prog   (prog),
    .cenb   (cenb),
    .inv    (inv),
    .min    (min),
    .mout   (mout),
    .moutb  (moutb),
    .sel_if (sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mout;
    logic busy;
    int   cur;
  } cyc_exp_t;

  typedef struct {
    int cyc;
    bit is_err;
    int sel;
  } evt_t;

  cyc_exp_t exp_q[$];
  evt_t     evt_q[$];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   started = 1'b0;

  // Timeline model: the output is enabled from m_run_at, the index reads
  // m_pend from m_cur_at (m_old before), m_mout is next cycle's output.
  int   m_run_at = 0;
  int   m_cur_at = 0;
  int   m_old = 0;
  int   m_pend = 0;
  logic m_mout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: record expectations, drive inputs, advance the model.
  task automatic step(input logic r, input logic p, input logic ce, input logic iv,
                      input logic [N-1:0] mn, input logic v, input logic [SW-1:0] rq);
    cyc_exp_t e;
    evt_t     ev;
    evt_t     keep[$];
    bit       running;
    int       cur;
    running = (cyc >= m_run_at);
    cur     = (cyc >= m_cur_at) ? m_pend : m_old;
    e.mout  = m_mout;
    e.busy  = !running;
    e.cur   = cur;
    exp_q.push_back(e);

    rst = r; prog = p; cenb = ce; inv = iv; min = mn;
    sif.sel_vld = v; sif.sel_req = rq;

    if (r) begin
      m_mout   = 1'b0;
      m_run_at = cyc + 1;
      m_cur_at = 0;
      m_old    = 0;
      m_pend   = 0;
      foreach (evt_q[i]) if (evt_q[i].cyc <= cyc) keep.push_back(evt_q[i]);
      evt_q = keep;
    end else begin
      m_mout = running & ~ce & ~p & (mn[cur] ^ iv);
      if (running && v) begin
        if (int'(rq) >= N) begin
          ev.cyc = cyc + 1; ev.is_err = 1'b1; ev.sel = cur;
        end else if (int'(rq) == cur) begin
          ev.cyc = cyc + 1; ev.is_err = 1'b0; ev.sel = cur;
        end else begin
          m_old    = cur;
          m_pend   = int'(rq);
          m_cur_at = cyc + D + 2;
          m_run_at = cyc + D + S + 2;
          ev.cyc = m_run_at; ev.is_err = 1'b0; ev.sel = int'(rq);
        end
        evt_q.push_back(ev);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic p, input logic [N-1:0] mn);
    for (int k = 0; k < n; k++) step(1'b0, p, 1'b0, 1'b0, mn, 1'b0, '0);
  endtask

  // Monitor: per-cycle output check plus done/err event scoreboard.
  always @(negedge clk) begin
    cyc_exp_t e;
    evt_t     ev;
    logic     exp_b;
    logic     exp_rdy;
    logic     exp_done;
    if (started) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_b   = ~e.mout;
        exp_rdy = ~e.busy;
        chk("mout", mout, e.mout);
        chk("moutb", moutb, exp_b);
        chk("busy", sif.busy, e.busy);
        chk("sel_rdy", sif.sel_rdy, exp_rdy);
        chk("cur_sel", sif.cur_sel, e.cur);
      end
      while (evt_q.size() > 0 && evt_q[0].cyc < cyc) begin
        ev = evt_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL event_missing at cycle %0d: got none expected %s at cycle %0d",
                 cyc, ev.is_err ? "err" : "done", ev.cyc);
      end
      if (sif.done === 1'b1 || sif.err === 1'b1) begin
        if (evt_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL event_unexpected at cycle %0d: got done=%0b err=%0b expected none",
                   cyc, sif.done, sif.err);
        end else begin
          ev = evt_q.pop_front();
          exp_done = ~ev.is_err;
          chk("event_cycle", cyc, ev.cyc);
          chk("event_err", sif.err, ev.is_err);
          chk("event_done", sif.done, exp_done);
          chk("event_sel", sif.cur_sel, ev.sel);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; prog = 1'b0; cenb = 1'b0; inv = 1'b0; min = '0;
    sif.sel_vld = 1'b0; sif.sel_req = '0;
    repeat (3) @(posedge clk);
    #1;
    started = 1'b1;

    // Reset state, selected input 0 of 12'h004 is low.
    idle(3, 1'b0, 12'h004);

    // Switch to index 2: output returns high once the sequence completes.
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h004, 1'b1, 4'd2);
    idle(9, 1'b0, 12'h004);

    // Out-of-range index rejected with err, then a same-index request.
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h004, 1'b1, 4'd12);
    idle(3, 1'b0, 12'h004);
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h004, 1'b1, 4'd2);
    idle(3, 1'b0, 12'h004);

    // Switch to 3 with prog raised during SETTLE and held past done.
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h00C, 1'b1, 4'd3);
    idle(3, 1'b0, 12'h00C);
    idle(5, 1'b1, 12'h00C);
    idle(4, 1'b0, 12'h00C);

    // Switch to 5 abandoned by reset at T+3.
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 1'b1, 4'd5);
    idle(2, 1'b0, 12'h020);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h020, 1'b0, '0);
    idle(8, 1'b0, 12'h020);

    // inv/cenb toggling in RUN with the selected input high.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, k[1], k[0], 12'h001, 1'b0, '0);
    end

    // Request held through a busy period is only taken once back in RUN.
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h081, 1'b1, 4'd7);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 12'h081, 1'b1, 4'd4);
    idle(10, 1'b0, 12'h081);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      logic          r_b;
      logic          p_b;
      logic          ce_b;
      logic          iv_b;
      logic [N-1:0]  mn_b;
      logic          v_b;
      logic [SW-1:0] rq_b;
      r_b  = ($urandom_range(0, 199) == 0);
      p_b  = ($urandom_range(0, 9) == 0);
      ce_b = ($urandom_range(0, 7) == 0);
      iv_b = 1'($urandom_range(0, 1));
      mn_b = N'($urandom);
      v_b  = ($urandom_range(0, 3) == 0);
      rq_b = SW'($urandom_range(0, (1 << SW) - 1));
      step(r_b, p_b, ce_b, iv_b, mn_b, v_b, rq_b);
    end

    idle(20, 1'b0, 12'h000);
    chk("events_drained", evt_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_mux_seq.md
CLK_MUX_SEQ -- requirements
Module: clk_mux_seq

Interface
REQ-001 Parameter N_IN, default 12: number of selectable inputs, legal range 2..64.
REQ-002 Parameter SEL_W, default $clog2(N_IN): width of the select index.
REQ-003 Parameter DRAIN_CYC, default 2: gated-off cycles before the select changes, legal range 1..15.
REQ-004 Parameter SETTLE_CYC, default 2: gated-off cycles after the select changes, legal range 1..15.
REQ-005 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-006 Port rst  in  1: reset, synchronous and active-high.
REQ-007 Port prog  in  1: programming mode; while high it forces mout low.
REQ-008 Port cenb  in  1: active-low output enable, sampled each cycle.
REQ-009 Port inv  in  1: when high, the selected input is inverted before gating.
REQ-010 Port min  in  N_IN: candidate inputs, sampled in the clk domain.
REQ-011 Port sel_req  in  SEL_W: requested select index.
REQ-012 Port sel_vld  in  1: sel_req is valid.
REQ-013 Port sel_rdy  out  1: block can accept a request.
REQ-014 Port mout  out  1: registered muxed and gated output.
REQ-015 Port moutb  out  1: combinational complement of mout.
REQ-016 Port cur_sel  out  SEL_W: currently applied select index.
REQ-017 Port busy  out  1: a switch sequence is in progress.
REQ-018 Port done  out  1: one-cycle pulse when a switch sequence completes.
REQ-019 Port err  out  1: one-cycle pulse when an out-of-range request is rejected.

Function
REQ-020 The FSM SHALL have four states: RUN, DRAIN, SWITCH and SETTLE.
REQ-021 sel_rdy SHALL be high only in RUN; a request is accepted on a cycle with sel_vld and sel_rdy both high.
REQ-022 An accepted request with sel_req >= N_IN SHALL pulse err on the next cycle, leave cur_sel unchanged and keep the FSM in RUN.
REQ-023 An accepted request with sel_req == cur_sel SHALL pulse done on the next cycle, stay in RUN and leave mout ungated.
REQ-024 An accepted in-range request to a different index SHALL latch a pending index and transition RUN->DRAIN.
REQ-025 The FSM SHALL stay in DRAIN for exactly DRAIN_CYC cycles, then enter SWITCH for one cycle.
REQ-026 In SWITCH the block SHALL load cur_sel from the pending index, then stay in SETTLE for exactly SETTLE_CYC cycles.
REQ-027 On leaving SETTLE the FSM SHALL return to RUN, and done SHALL be high for the first RUN cycle.
REQ-028 With a request accepted at cycle T, the FSM SHALL be in RUN again at cycle T+DRAIN_CYC+SETTLE_CYC+2.
REQ-029 gate SHALL be high only when the state is RUN and cenb is low.
REQ-030 mout SHALL update every cycle as mout <= gate & ~prog & (min[cur_sel] ^ inv).
REQ-031 mout SHALL therefore have one cycle of latency from min, and SHALL be low throughout DRAIN, SWITCH and SETTLE.
REQ-032 busy SHALL be high in DRAIN, SWITCH and SETTLE, and low in RUN.
REQ-033 prog SHALL only mask mout; a switch sequence in progress when prog asserts SHALL complete with unchanged timing.
REQ-034 sel_vld asserted while busy SHALL be ignored and not queued; the requester holds the request until sel_rdy is high.
REQ-035 Changes of inv or cenb SHALL take effect on mout one cycle after they are sampled, with no FSM involvement.
REQ-036 A single internal counter of 4 bits SHALL be reused for DRAIN and SETTLE, reloaded on each state entry.

Reset
REQ-037 While rst is high at a clock edge: state=RUN, cur_sel=0, pending index=0, counter=0, mout=0, done=0, err=0.
REQ-038 After reset, moutb SHALL be 1 and sel_rdy SHALL be 1 from the first cycle after rst deasserts.
REQ-039 rst asserted mid-sequence SHALL abandon the switch; cur_sel reads 0 and no done pulse is produced.

Structure
REQ-040 The package clk_mux_pkg SHALL hold the state enum, the default parameter constants and the counter width constant.
REQ-041 The N_IN:1 selector SHALL be a sub-module clk_mux_sel, parametrised by N_IN, with its output combinational to the top block.
REQ-042 Parameter legality SHALL be checked at elaboration.

Verification
REQ-043 Reset, then drive min=12'h004 with cur_sel=0, inv=0, cenb=0: mout=0 and moutb=1.
REQ-044 Request sel_req=2 at cycle T: busy for T+1..T+5, mout=0 in those cycles, cur_sel=2 from T+4, done at T+6, mout=1 from T+7.
REQ-045 Request sel_req=12 with N_IN=12: err pulses for one cycle, cur_sel and mout unchanged, busy stays 0.
REQ-046 Assert prog during SETTLE: done still arrives on schedule, and mout stays 0 until prog drops plus one cycle.
REQ-047 Assert rst at T+3 of a switch to index 5: the cycle after, state=RUN, cur_sel=0, done never pulses.
REQ-048 Toggle inv and cenb in RUN with selected input=1: mout follows 0/1 with one-cycle latency, and a sel_vld while busy is not accepted.
